// File: rtl/bcd_count_ctrl_if.sv
// bcd_count_ctrl_if: control/status bundle between the BCD run controller and its user/counter side.
interface bcd_count_ctrl_if;
  logic        start;
  logic        stop;
  logic        clear;
  logic        auto_reload;
  logic [11:0] target;
  logic [11:0] digits_in;
  logic        cnt_en;
  logic        cnt_clr;
  logic        running;
  logic        done;
  logic        tgt_err;
  logic [1:0]  state;
  modport master (
    output start, stop, clear, auto_reload, target, digits_in,
    input  cnt_en, cnt_clr, running, done, tgt_err, state
  );
  modport slave (
    input  start, stop, clear, auto_reload, target, digits_in,
    output cnt_en, cnt_clr, running, done, tgt_err, state
  );
endinterface

// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: prescaled start/stop/clear run controller for a 3-digit BCD counter.
// Define CTRL_SYNC_EN to treat start/stop/clear as async buttons (2-flop sync + rising-edge detect).
module bcd_count_ctrl #(
  parameter int PRESCALE = 4,
  parameter int PW       = 16
) (
  input logic             clk,
  input logic             rst,
  bcd_count_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          start_p, stop_p, clear_p;
  logic          go, hit;
`ifdef CTRL_SYNC_EN
  logic [2:0] s1_q, s2_q, s3_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= {bus.clear, bus.stop, bus.start};
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  assign {clear_p, stop_p, start_p} = s2_q & ~s3_q;
`else
  assign {clear_p, stop_p, start_p} = {bus.clear, bus.stop, bus.start};
`endif
  assign bus.tgt_err = (bus.target[11:8] > 4'd9) | (bus.target[7:4] > 4'd9) | (bus.target[3:0] > 4'd9);
  assign go = start_p && !stop_p && !bus.tgt_err;
  // While our own clear pulse is in flight digits_in still shows the old value, so it must not re-match.
  assign hit = (bus.digits_in == bus.target) && !cnt_clr_q;
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;
    if (clear_p) begin
      state_d   = IDLE;
      presc_d   = '0;
      cnt_clr_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (go) begin
          state_d = RUN;
          presc_d = '0;
        end
        RUN: if (stop_p || bus.tgt_err) begin
          state_d = PAUSE;
        end else if (hit) begin
          state_d   = bus.auto_reload ? RUN : DONE;
          presc_d   = '0;
          cnt_clr_d = bus.auto_reload;
        end else begin
          cnt_en_d = presc_q == LAST;
          presc_d  = (presc_q == LAST) ? '0 : presc_q + PW'(1);
        end
        PAUSE: if (go) state_d = RUN;
        DONE: if (go) begin
          state_d   = RUN;
          presc_d   = '0;
          cnt_clr_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
    end
  assign bus.cnt_en  = cnt_en_q;
  assign bus.cnt_clr = cnt_clr_q;
  assign bus.running = state_q == RUN;
  assign bus.done    = state_q == DONE;
  assign bus.state   = state_q;
endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb_bcd_count_ctrl: vector tables plus a tick/clear scoreboard against an attached BCD counter model.
module tb_bcd_count_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bcd_count_ctrl_if bus();
  bcd_count_ctrl #(.PRESCALE(4), .PW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {logic [11:0] tgt; logic err;} err_vec_t;
  typedef struct {logic [2:0] cmd; logic [11:0] tgt; logic [1:0] es; logic ec;} fsm_vec_t;
  err_vec_t    ev[6];
  fsm_vec_t    fv[17];
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  logic [11:0] digits;
  bit          sb_on = 1'b0;
  bit          no_done = 1'b0;
  int          tick_q[$];
  int          clr_q[$];
  assign bus.digits_in = digits;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [11:0] bcd_inc(input logic [11:0] d);
    if (d[3:0] != 4'd9) return {d[11:4], d[3:0] + 4'd1};
    if (d[7:4] != 4'd9) return {d[11:8], d[7:4] + 4'd1, 4'd0};
    if (d[11:8] != 4'd9) return {d[11:8] + 4'd1, 8'd0};
    return 12'd0;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) digits <= 12'd0;
    else if (bus.cnt_clr) digits <= 12'd0;
    else if (bus.cnt_en) digits <= bcd_inc(digits);
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, got, got, exp, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_until(input int n);
    while (cyc < n) step();
  endtask
  task automatic cmd(input logic [2:0] c);
    {bus.clear, bus.stop, bus.start} = c;
    step();
    {bus.clear, bus.stop, bus.start} = 3'b000;
  endtask
  always @(negedge clk)
    if (sb_on && !rst) begin
      if (bus.cnt_en) begin
        if (tick_q.size() == 0) chk("extra_cnt_en", bus.cnt_en, 0);
        else chk("tick_cycle", cyc, tick_q.pop_front());
      end
      if (bus.cnt_clr) begin
        if (clr_q.size() == 0) chk("extra_cnt_clr", bus.cnt_clr, 0);
        else chk("clr_cycle", cyc, clr_q.pop_front());
      end
      if (no_done && bus.done) chk("done_in_reload", bus.done, 0);
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    ev[0] = '{12'h000, 1'b0};
    ev[1] = '{12'h999, 1'b0};
    ev[2] = '{12'h00A, 1'b1};
    ev[3] = '{12'h0A0, 1'b1};
    ev[4] = '{12'hF00, 1'b1};
    ev[5] = '{12'h909, 1'b0};
    fv[0]  = '{3'b010, 12'h999, 2'b00, 1'b0};
    fv[1]  = '{3'b011, 12'h999, 2'b00, 1'b0};
    fv[2]  = '{3'b001, 12'h999, 2'b01, 1'b0};
    fv[3]  = '{3'b000, 12'h999, 2'b01, 1'b0};
    fv[4]  = '{3'b010, 12'h999, 2'b10, 1'b0};
    fv[5]  = '{3'b011, 12'h999, 2'b10, 1'b0};
    fv[6]  = '{3'b010, 12'h999, 2'b10, 1'b0};
    fv[7]  = '{3'b001, 12'h999, 2'b01, 1'b0};
    fv[8]  = '{3'b111, 12'h999, 2'b00, 1'b1};
    fv[9]  = '{3'b000, 12'h999, 2'b00, 1'b0};
    fv[10] = '{3'b100, 12'h999, 2'b00, 1'b1};
    fv[11] = '{3'b001, 12'h0A0, 2'b00, 1'b0};
    fv[12] = '{3'b001, 12'h999, 2'b01, 1'b0};
    fv[13] = '{3'b000, 12'h0A0, 2'b10, 1'b0};
    fv[14] = '{3'b001, 12'h999, 2'b01, 1'b0};
    fv[15] = '{3'b100, 12'h999, 2'b00, 1'b1};
    fv[16] = '{3'b000, 12'h999, 2'b00, 1'b0};
    {bus.clear, bus.stop, bus.start} = 3'b000;
    bus.auto_reload = 1'b0;
    bus.target = 12'h005;
    step();
    step();
    chk("rst_state", bus.state, 0);
    chk("rst_cnt_en", bus.cnt_en, 0);
    chk("rst_cnt_clr", bus.cnt_clr, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tgt_err", bus.tgt_err, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.target = ev[i].tgt;
      #1;
      chk($sformatf("tgt_err%0d", i), bus.tgt_err, ev[i].err);
    end
    step();
`ifdef CTRL_SYNC_EN
    begin : sync_test
      int k, first, entries;
      logic prev;
      bus.target = 12'h999;
      step();
      k = cyc;
      first = -1;
      entries = 0;
      prev = bus.running;
      bus.start = 1'b1;
      for (int i = 0; i < 25; i++) begin
        if (i == 20) bus.start = 1'b0;
        step();
        if (bus.running && !prev) begin
          entries++;
          if (first < 0) first = cyc;
        end
        prev = bus.running;
      end
      chk("sync_entry_cycle", first, k + 3);
      chk("sync_entries", entries, 1);
    end
`else
    begin : main_tests
      int e, r;
      for (int i = 0; i < 17; i++) begin
        bus.target = fv[i].tgt;
        cmd(fv[i].cmd);
        chk($sformatf("fsm%0d_state", i), bus.state, fv[i].es);
        chk($sformatf("fsm%0d_clr", i), bus.cnt_clr, fv[i].ec);
        chk($sformatf("fsm%0d_running", i), bus.running, fv[i].es == 2'b01);
      end
      step();
      bus.target = 12'h005;
      e = cyc + 1;
      for (int k = 1; k <= 5; k++) tick_q.push_back(e + 4 * k);
      sb_on = 1'b1;
      cmd(3'b001);
      chk("t1_running", bus.running, 1);
      for (int i = 0; i < 60 && !bus.done; i++) step();
      chk("t1_done_cycle", cyc, e + 22);
      chk("t1_digits", digits, 12'h005);
      repeat (10) step();
      chk("t1_state_done", bus.state, 3);
      chk("t1_ticks_left", tick_q.size(), 0);
      sb_on = 1'b0;
      cmd(3'b001);
      chk("t1_restart_state", bus.state, 1);
      chk("t1_restart_clr", bus.cnt_clr, 1);
      step();
      chk("t1_restart_hold", bus.state, 1);
      chk("t1_restart_clr_off", bus.cnt_clr, 0);
      chk("t1_restart_digits", digits, 12'h000);
      cmd(3'b100);
      step();
      bus.target = 12'h999;
      e = cyc + 1;
      tick_q.push_back(e + 4);
      sb_on = 1'b1;
      cmd(3'b001);
      wait_until(e + 6);
      cmd(3'b010);
      chk("t2_paused", bus.state, 2);
      wait_until(e + 17);
      chk("t2_pause_digits", digits, 12'h001);
      chk("t2_still_paused", bus.state, 2);
      r = cyc + 1;
      tick_q.push_back(r + 2);
      tick_q.push_back(r + 6);
      cmd(3'b001);
      chk("t2_resumed", bus.state, 1);
      wait_until(r + 7);
      chk("t2_digits", digits, 12'h003);
      chk("t2_ticks_left", tick_q.size(), 0);
      sb_on = 1'b0;
      cmd(3'b100);
      step();
      bus.target = 12'h003;
      bus.auto_reload = 1'b1;
      e = cyc + 1;
      foreach (ev[i]) begin end
      for (int p = 0; p < 3; p++) begin
        for (int k = 1; k <= 3; k++) tick_q.push_back(e + 14 * p + 4 * k);
        clr_q.push_back(e + 14 * p + 14);
      end
      sb_on = 1'b1;
      no_done = 1'b1;
      cmd(3'b001);
      wait_until(e + 44);
      chk("t3_running", bus.running, 1);
      chk("t3_ticks_left", tick_q.size(), 0);
      chk("t3_clrs_left", clr_q.size(), 0);
      sb_on = 1'b0;
      no_done = 1'b0;
      bus.auto_reload = 1'b0;
      cmd(3'b100);
      step();
      bus.target = 12'h999;
      e = cyc + 1;
      cmd(3'b001);
      wait_until(e + 4);
      chk("t6_pre_cnt_en", bus.cnt_en, 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_state", bus.state, 0);
      chk("t6_cnt_en", bus.cnt_en, 0);
      chk("t6_cnt_clr", bus.cnt_clr, 0);
      chk("t6_running", bus.running, 0);
      chk("t6_done", bus.done, 0);
      step();
      rst = 1'b0;
      e = cyc + 1;
      tick_q.push_back(e + 4);
      sb_on = 1'b1;
      cmd(3'b001);
      wait_until(e + 5);
      chk("t6_post_ticks_left", tick_q.size(), 0);
      sb_on = 1'b0;
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
